tape_demod: RTL

TAPE_DEMOD -- requirements
Module: tape_demod

---
 rtl/tape_pkg.sv | 12 +
 rtl/tape_interval_meter.sv | 49 ++++
 rtl/tape_demod.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/tape_pkg.sv
// Shared types and constants for the cassette tape demodulator.
package tape_pkg;
  localparam int INTERVAL_W = 16;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hE6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEADER = 2'd1,
    SYNC   = 2'd2,
    DATA   = 2'd3
  } tape_state_e;
endpackage

// File: rtl/tape_interval_meter.sv
// Synchronizes the slicer output and measures the clk18 cycles between transitions.
module tape_interval_meter
  import tape_pkg::*;
(
  input  logic                  clk18,
  input  logic                  reset_n,
  input  logic                  tapein,
  output logic                  tape_edge,
  output logic                  level,
  output logic [INTERVAL_W-1:0] interval,
  output logic [INTERVAL_W-1:0] count
);

  logic                  sync_p0, sync_p1, level_p2;
  logic                  edge_now;
  logic [INTERVAL_W-1:0] count_q;

  function automatic logic [INTERVAL_W-1:0] sat_inc(input logic [INTERVAL_W-1:0] v);
    return (v == {INTERVAL_W{1'b1}}) ? v : v + INTERVAL_W'(1);
  endfunction

  assign edge_now = sync_p1 ^ level_p2;
  assign level    = level_p2;
  assign count    = count_q;

  always_ff @(posedge clk18 or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0   <= 1'b0;
      sync_p1   <= 1'b0;
      level_p2  <= 1'b0;
      tape_edge <= 1'b0;
      interval  <= '0;
      count_q   <= '0;
    end else begin
      sync_p0   <= tapein;
      sync_p1   <= sync_p0;
      // p2: previous level, registered edge strobe and latched interval
      level_p2  <= sync_p1;
      tape_edge <= edge_now;
      if (edge_now) begin
        interval <= count_q;
        count_q  <= INTERVAL_W'(1);
      end else begin
        count_q  <= sat_inc(count_q);
      end
    end
  end

endmodule

// File: rtl/tape_demod.sv
// Manchester tape decoder: leader lock, byte alignment on SYNC_BYTE, byte output.
module tape_demod
  import tape_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEF,
  parameter logic [15:0] MIN_HALF   = 16'd900,
  parameter logic [15:0] MAX_HALF   = 16'd18000,
  parameter int          LEADER_CNT = 16,
  parameter bit          INVERT     = 1'b0
)(
  input  logic       clk18,
  input  logic       reset_n,
  input  logic       tapein,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       carrier,
  output logic       synced
);

  localparam int W     = INTERVAL_W;
  localparam int ACC_W = 20;
  localparam int THR_W = W + 2;

  logic             tape_edge, level;
  logic [W-1:0]     interval, count;
  tape_state_e      state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic [7:0]       lcnt_q, lcnt_d;
  logic [W-1:0]     t_half_q, t_half_d, new_half;
  logic [THR_W-1:0] thr_q, thr_d, tmo_q, tmo_d, new_thr;
  logic [7:0]       shreg_q, shreg_d, shreg_next;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic             mid_q, mid_d, mid_next;
  logic [7:0]       data_d;
  logic             data_valid_d;
  logic             legal, is_short, is_long, too_short, timeout, bit_in;

  tape_interval_meter u_meter (
    .clk18     (clk18),
    .reset_n   (reset_n),
    .tapein    (tapein),
    .tape_edge (tape_edge),
    .level     (level),
    .interval  (interval),
    .count     (count)
  );

  // Lock thresholds derive from the mean of the leader half-bits (sum of 16 >> 4).
  assign acc_sum    = acc_q + ACC_W'(interval);
  assign new_half   = acc_sum[ACC_W-1:4];
  assign new_thr    = THR_W'(new_half) + THR_W'(new_half >> 1);
  assign legal      = (interval >= MIN_HALF) && (interval <= MAX_HALF);
  assign is_short   = THR_W'(interval) < thr_q;
  assign is_long    = !is_short && (THR_W'(interval) < tmo_q);
  assign too_short  = interval < (t_half_q >> 1);
  assign timeout    = THR_W'(count) >= tmo_q;
  assign bit_in     = level ^ INVERT;
  assign shreg_next = {shreg_q[6:0], bit_in};
  assign mid_next   = is_long ? 1'b1 : ~mid_q;
  assign carrier    = (state_q != IDLE);
  assign synced     = (state_q == DATA);

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    lcnt_d       = lcnt_q;
    t_half_d     = t_half_q;
    thr_d        = thr_q;
    tmo_d        = tmo_q;
    shreg_d      = shreg_q;
    bitcnt_d     = bitcnt_q;
    mid_d        = mid_q;
    data_d       = data;
    data_valid_d = 1'b0;
    if (state_q == IDLE) begin
      if (tape_edge && legal) begin
        if (lcnt_q == 8'(LEADER_CNT - 1)) begin
          state_d  = LEADER;
          t_half_d = new_half;
          thr_d    = new_thr;
          tmo_d    = {new_thr[THR_W-2:0], 1'b0};
          acc_d    = '0;
          lcnt_d   = '0;
          mid_d    = 1'b0;
        end else begin
          acc_d  = acc_sum;
          lcnt_d = lcnt_q + 8'd1;
        end
      end else if (tape_edge || (count == {W{1'b1}})) begin
        acc_d  = '0;
        lcnt_d = '0;
      end
    end else if (timeout || (tape_edge && too_short)) begin
      // Carrier lost: drop back and discard any partial byte.
      state_d  = IDLE;
      acc_d    = '0;
      lcnt_d   = '0;
      bitcnt_d = '0;
      mid_d    = 1'b0;
    end else if (tape_edge && (is_short || is_long)) begin
      mid_d = mid_next;
      if ((state_q == LEADER) && is_long)
        state_d = SYNC;
      if (mid_next) begin
        shreg_d = shreg_next;
        if ((state_q == SYNC) && (shreg_next == SYNC_BYTE)) begin
          state_d  = DATA;
          bitcnt_d = '0;
        end else if (state_q == DATA) begin
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            data_d       = shreg_next;
            data_valid_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk18 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      lcnt_q     <= '0;
      t_half_q   <= '0;
      thr_q      <= '0;
      tmo_q      <= '0;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
      mid_q      <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      lcnt_q     <= lcnt_d;
      t_half_q   <= t_half_d;
      thr_q      <= thr_d;
      tmo_q      <= tmo_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
      mid_q      <= mid_d;
      data       <= data_d;
      data_valid <= data_valid_d;
    end
  end

endmodule
